// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment types and the hex-to-segment code table.
package seg_pkg;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h00;

    // Active-high segment codes {g,f,e,d,c,b,a}, indexed by hex value.
    localparam seg_t SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: combinational hex digit to active-high 7-segment code.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);
    assign seg_o = SEG_TABLE[hex_i];
endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: multiplexed N-digit 7-segment scan driver with per-frame snapshot and blanking gap.
// Optional leading-zero blanking is built when SCAN_LZB_EN is defined.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DWELL          = 50000,
    parameter int BLANK          = 500,
    parameter int SEL_ACTIVE_LOW = 0,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_blank,
    output logic [NUM_DIGITS-1:0]   sel,
    output logic [6:0]              leds,
    output logic                    frame_start
);
    localparam int PW = DWELL > 1 ? $clog2(DWELL) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRE_LAST = PW'(DWELL - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_INV = SEL_ACTIVE_LOW != 0 ? '1 : '0;
    localparam seg_t SEG_INV = SEG_ACTIVE_LOW != 0 ? 7'h7F : 7'h00;

    logic [PW-1:0] presc_q, presc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0] snap_dig_q, snap_dig_d, slot_dig;
    logic [NUM_DIGITS-1:0] snap_blk_q, snap_blk_d, lzb, sel_raw;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    seg_t leds_q, leds_d, dec_seg;
    logic fs_q, fs_d, take, wrap, show;
    logic [3:0] cur_dig;

    // Digit 0 is the leftmost (most significant) nibble of the bus.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) slot_dig[i] = digits[4*(NUM_DIGITS-1-i) +: 4];
    end

`ifdef SCAN_LZB_EN
    logic zero_run;
    always_comb begin
        zero_run = 1'b1;
        lzb = '0;
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            zero_run = zero_run && slot_dig[i] == 4'h0;
            lzb[i] = zero_run;
        end
    end
`else
    assign lzb = '0;
`endif

    // Slot 0 begins whenever the counters sit at zero while enabled; this also
    // covers the first cycle after reset or an enable rise.
    always_comb begin
        take = enable && presc_q == '0 && idx_q == '0;
        wrap = presc_q == PRE_LAST;
        presc_d = (!enable || wrap) ? '0 : presc_q + 1'b1;
        idx_d = !enable ? '0 : !wrap ? idx_q : (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        snap_dig_d = take ? slot_dig : snap_dig_q;
        snap_blk_d = take ? (digit_blank | lzb) : snap_blk_q;
        fs_d = take;
    end

    // Outputs read the post-capture snapshot so the first slot of a frame is never torn.
    assign cur_dig = snap_dig_d[idx_q];

    seg_hex_decoder u_dec (
        .hex_i (cur_dig),
        .seg_o (dec_seg)
    );

    always_comb begin
        show = enable && 32'(presc_q) >= 32'(BLANK);
        sel_raw = '0;
        for (int i = 0; i < NUM_DIGITS; i++) sel_raw[NUM_DIGITS-1-i] = show && idx_q == IW'(i);
        sel_d = sel_raw ^ SEL_INV;
        leds_d = ((show && !snap_blk_d[idx_q]) ? dec_seg : SEG_OFF) ^ SEG_INV;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            idx_q      <= '0;
            snap_dig_q <= '0;
            snap_blk_q <= '0;
            sel_q      <= SEL_INV;
            leds_q     <= SEG_INV;
            fs_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            snap_dig_q <= snap_dig_d;
            snap_blk_q <= snap_blk_d;
            sel_q      <= sel_d;
            leds_q     <= leds_d;
            fs_q       <= fs_d;
        end
    end

    assign sel         = sel_q;
    assign leds        = leds_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: self-checking bench for seg_scan_mux (two builds: plain and inverted polarity, no blank).
module tb_seg_scan_mux;
`ifdef SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, en;
    logic [15:0] dig0, dig1;
    logic [3:0] blk;
    logic [3:0] sel0, sel1;
    logic [6:0] led0, led1;
    logic fs0, fs1;

    int total = 0;
    int bad = 0;
    int k;
    logic [3:0] sd0 [4], sd1 [4];
    logic sb0 [4], sb1 [4];
    logic [6:0] seg_code [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  blk;
        logic [3:0]  sel;
        logic [6:0]  leds;
        logic        fs;
    } vec_t;
    vec_t vt [17];

    seg_scan_mux #(.NUM_DIGITS(4), .DWELL(4), .BLANK(1)) u0 (
        .clk(clk), .rst_n(rst_n), .enable(en), .digits(dig0), .digit_blank(blk),
        .sel(sel0), .leds(led0), .frame_start(fs0)
    );

    seg_scan_mux #(.NUM_DIGITS(4), .DWELL(4), .BLANK(0), .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(en), .digits(dig1), .digit_blank(blk),
        .sel(sel1), .leds(led1), .frame_start(fs1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Leftmost digits are auto-blanked while every digit up to them is zero; the last digit never is.
    function automatic bit lz(input logic [15:0] d, input int i);
        int first = 3;
        for (int j = 2; j >= 0; j--) if (d[4*(3-j) +: 4] != 4'h0) first = j;
        return LZB && i < first;
    endfunction

    function automatic logic [15:0] rnd16();
        logic [15:0] d;
        for (int i = 0; i < 4; i++) d[4*i +: 4] = $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom);
        return d;
    endfunction

    // Reference: k counts cycles since slot 0 of the current run began; the frame is 16 cycles.
    task automatic tick();
        logic [3:0] es0, es1;
        logic [6:0] el0, el1;
        logic efs;
        int sl, ph;
        es0 = '0; es1 = '0; el0 = '0; el1 = '0; efs = 1'b0;
        if (!rst_n) begin
            k = 0;
            for (int i = 0; i < 4; i++) begin
                sd0[i] = '0; sd1[i] = '0; sb0[i] = 1'b0; sb1[i] = 1'b0;
            end
        end else if (!en) begin
            k = 0;
        end else begin
            efs = (k % 16) == 0;
            if (efs) begin
                for (int i = 0; i < 4; i++) begin
                    sd0[i] = dig0[4*(3-i) +: 4];
                    sd1[i] = dig1[4*(3-i) +: 4];
                    sb0[i] = blk[i] | lz(dig0, i);
                    sb1[i] = blk[i] | lz(dig1, i);
                end
            end
            sl = (k / 4) % 4;
            ph = k % 4;
            if (ph >= 1) begin
                es0 = 4'b1000 >> sl;
                el0 = sb0[sl] ? 7'h00 : seg_code[sd0[sl]];
            end
            es1 = 4'b1000 >> sl;
            el1 = sb1[sl] ? 7'h00 : seg_code[sd1[sl]];
            k++;
        end
        es1 = ~es1;
        el1 = ~el1;
        @(posedge clk);
        #1;
        chk("sel0", sel0, es0);
        chk("leds0", led0, el0);
        chk("fs0", fs0, efs);
        chk("sel1", sel1, es1);
        chk("leds1", led1, el1);
        chk("fs1", fs1, efs);
    endtask

    initial begin
        logic [6:0] old_code [4];
        logic [6:0] lzb_code [4];
        old_code = '{7'h00, 7'h5B, 7'h77, 7'h71};
        lzb_code = '{7'h00, 7'h00, 7'h6D, 7'h3F};
        vt[0]  = '{16'h12AF, 4'h0, 4'b0000, 7'h00, 1'b1};
        vt[1]  = '{16'h12AF, 4'h0, 4'b1000, 7'h06, 1'b0};
        vt[2]  = '{16'h12AF, 4'h0, 4'b1000, 7'h06, 1'b0};
        vt[3]  = '{16'h12AF, 4'h0, 4'b1000, 7'h06, 1'b0};
        vt[4]  = '{16'h12AF, 4'h0, 4'b0000, 7'h00, 1'b0};
        vt[5]  = '{16'h12AF, 4'h0, 4'b0100, 7'h5B, 1'b0};
        vt[6]  = '{16'h12AF, 4'h0, 4'b0100, 7'h5B, 1'b0};
        vt[7]  = '{16'h12AF, 4'h0, 4'b0100, 7'h5B, 1'b0};
        vt[8]  = '{16'h12AF, 4'h0, 4'b0000, 7'h00, 1'b0};
        vt[9]  = '{16'h12AF, 4'h0, 4'b0010, 7'h77, 1'b0};
        vt[10] = '{16'h12AF, 4'h0, 4'b0010, 7'h77, 1'b0};
        vt[11] = '{16'h12AF, 4'h0, 4'b0010, 7'h77, 1'b0};
        vt[12] = '{16'h12AF, 4'h0, 4'b0000, 7'h00, 1'b0};
        vt[13] = '{16'h12AF, 4'h0, 4'b0001, 7'h71, 1'b0};
        vt[14] = '{16'h12AF, 4'h0, 4'b0001, 7'h71, 1'b0};
        vt[15] = '{16'h12AF, 4'h0, 4'b0001, 7'h71, 1'b0};
        vt[16] = '{16'h12AF, 4'h0, 4'b0000, 7'h00, 1'b1};

        rst_n = 1'b0; en = 1'b1; dig0 = 16'h12AF; dig1 = 16'h0000; blk = 4'h0; k = 0;
        tick();
        tick();
        chk("rst_sel1", sel1, 4'hF);
        chk("rst_leds1", led1, 7'h7F);
        chk("rst_sel0", sel0, 4'h0);
        rst_n = 1'b1;

        // First frame after reset, plus wrap into the next frame_start.
        for (int i = 0; i < 17; i++) begin
            dig0 = vt[i].dig;
            blk = vt[i].blk;
            tick();
            chk("vec_sel", sel0, vt[i].sel);
            chk("vec_leds", led0, vt[i].leds);
            chk("vec_fs", fs0, vt[i].fs);
            if (i == 0) begin
                chk("pol_sel", sel1, 4'b0111);
                chk("pol_leds", led1, LZB ? 7'h7F : 7'h40);
            end
        end

        // Input change mid-frame must not tear the frame in progress.
        repeat (3) tick();
        dig0 = 16'h3333;
        for (int s = 1; s < 4; s++)
            for (int p = 0; p < 4; p++) begin
                tick();
                if (p > 0) chk("snap_hold", led0, old_code[s]);
            end
        tick();
        chk("snap_fs", fs0, 1'b1);
        tick();
        chk("snap_new", led0, 7'h4F);

        // Per-digit blanking keeps the select but darkens the segments.
        blk = 4'b0100;
        dig0 = 16'h8888;
        repeat (14) tick();
        for (int s = 0; s < 4; s++)
            for (int p = 0; p < 4; p++) begin
                tick();
                if (p > 0) begin
                    chk("blank_sel", sel0, 4'b1000 >> s);
                    chk("blank_leds", led0, s == 2 ? 7'h00 : 7'h7F);
                end
            end

        // Drop enable in the middle of slot 2, then restart.
        repeat (9) tick();
        en = 1'b0;
        tick();
        chk("dis_sel", sel0, 4'h0);
        chk("dis_leds", led0, 7'h00);
        chk("dis_fs", fs0, 1'b0);
        repeat (2) tick();
        en = 1'b1;
        tick();
        chk("ren_fs", fs0, 1'b1);
        chk("ren_blank", sel0, 4'h0);
        tick();
        chk("ren_sel", sel0, 4'b1000);
        chk("ren_leds", led0, 7'h7F);
        blk = 4'h0;

`ifdef SCAN_LZB_EN
        repeat (14) tick();
        dig0 = 16'h0050;
        dig1 = 16'h0000;
        for (int s = 0; s < 4; s++)
            for (int p = 0; p < 4; p++) begin
                tick();
                if (p > 0) chk("lzb0", led0, lzb_code[s]);
                chk("lzb1", led1, s == 3 ? 7'h40 : 7'h7F);
            end
`endif

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) dig0 = rnd16();
            if ($urandom_range(0, 7) == 0) dig1 = rnd16();
            if ($urandom_range(0, 15) == 0) blk = 4'($urandom);
            if ($urandom_range(0, 39) == 0) en = ~en;
            rst_n = $urandom_range(0, 499) != 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
